// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD stopwatch driven by a slow divider output sampled in the fast clkin domain.
// The divider output and the keys are synchronized and edge-detected here; only rising edges act.
// Optional lap-hold feature: define LAP_EN to add key_lap / lapheld.
module stopwatch_bcd_counter #(
    parameter int TICKS_PER_INC = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       tickin,
    input  logic       key_startstop,
    input  logic       key_clear,
`ifdef LAP_EN
    input  logic       key_lap,
    output logic       lapheld,
`endif
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    // Conditioned input bit positions: tick, start/stop, clear (and lap when enabled).
    localparam int IDX_TICK = 0;
    localparam int IDX_SS   = 1;
    localparam int IDX_CLR  = 2;
`ifdef LAP_EN
    localparam int NIN      = 4;
    localparam int IDX_LAP  = 3;
`else
    localparam int NIN      = 3;
`endif

    // Prescaler terminal count; the prescaler rolls over here and issues one increment.
    localparam logic [15:0] TERM = 16'(TICKS_PER_INC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_t;

    logic [NIN-1:0] w_raw;
    logic [NIN-1:0] r_sync [SYNC_STAGES];
    logic [NIN-1:0] r_hist;
    logic [NIN-1:0] w_rise;

    logic w_tickRise;
    logic w_ssRise;
    logic w_clrRise;

    state_t r_state;
    state_t w_nextState;
    logic   r_running;

    logic [15:0] r_prescale;
    logic [3:0]  r_secOnes;
    logic [3:0]  r_secTens;
    logic [3:0]  r_minOnes;
    logic [3:0]  r_minTens;
    logic        r_wrap;

`ifdef LAP_EN
    assign w_raw = {key_lap, key_clear, key_startstop, tickin};
`else
    assign w_raw = {key_clear, key_startstop, tickin};
`endif

    // Synchronizer chain plus one history flop per conditioned input.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_tickRise = w_rise[IDX_TICK];
    assign w_ssRise   = w_rise[IDX_SS];
    assign w_clrRise  = w_rise[IDX_CLR];

    // State register; running is registered alongside so it changes with the state.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_running <= (w_nextState == S_RUN);
        end
    end

    // Next-state decode: clear wins over start/stop from any state.
    always_comb begin
        w_nextState = r_state;
        if (w_clrRise) begin
            w_nextState = S_IDLE;
        end else if (w_ssRise) begin
            case (r_state)
                S_IDLE:  w_nextState = S_RUN;
                S_RUN:   w_nextState = S_PAUSE;
                S_PAUSE: w_nextState = S_RUN;
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // Prescaler and BCD ripple counter; ticks are judged against the state before any key action.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_secOnes  <= '0;
            r_secTens  <= '0;
            r_minOnes  <= '0;
            r_minTens  <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_clrRise) begin
                r_prescale <= '0;
                r_secOnes  <= '0;
                r_secTens  <= '0;
                r_minOnes  <= '0;
                r_minTens  <= '0;
            end else if ((r_state == S_RUN) && w_tickRise) begin
                if (r_prescale == TERM) begin
                    r_prescale <= '0;
                    if (r_secOnes != 4'd9) begin
                        r_secOnes <= r_secOnes + 4'd1;
                    end else begin
                        r_secOnes <= '0;
                        if (r_secTens != 4'd5) begin
                            r_secTens <= r_secTens + 4'd1;
                        end else begin
                            r_secTens <= '0;
                            if (r_minOnes != 4'd9) begin
                                r_minOnes <= r_minOnes + 4'd1;
                            end else begin
                                r_minOnes <= '0;
                                if (r_minTens != 4'd5) begin
                                    r_minTens <= r_minTens + 4'd1;
                                end else begin
                                    r_minTens <= '0;
                                    r_wrap    <= 1'b1;
                                end
                            end
                        end
                    end
                end else begin
                    r_prescale <= r_prescale + 16'd1;
                end
            end
        end
    end

`ifdef LAP_EN
    logic       w_lapRise;
    logic       r_lapHeld;
    logic [3:0] r_lapSecOnes;
    logic [3:0] r_lapSecTens;
    logic [3:0] r_lapMinOnes;
    logic [3:0] r_lapMinTens;

    assign w_lapRise = w_rise[IDX_LAP];

    // Lap capture/release; only honoured in RUN, dropped on clear or when start/stop leaves RUN.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_lapHeld    <= 1'b0;
            r_lapSecOnes <= '0;
            r_lapSecTens <= '0;
            r_lapMinOnes <= '0;
            r_lapMinTens <= '0;
        end else begin
            if (w_clrRise) begin
                r_lapHeld <= 1'b0;
            end else if (w_ssRise && (r_state == S_RUN)) begin
                r_lapHeld <= 1'b0;
            end else if (w_lapRise && (r_state == S_RUN)) begin
                if (r_lapHeld) begin
                    r_lapHeld <= 1'b0;
                end else begin
                    r_lapHeld    <= 1'b1;
                    r_lapSecOnes <= r_secOnes;
                    r_lapSecTens <= r_secTens;
                    r_lapMinOnes <= r_minOnes;
                    r_lapMinTens <= r_minTens;
                end
            end
        end
    end

    assign lapheld  = r_lapHeld;
    assign sec_ones = r_lapHeld ? r_lapSecOnes : r_secOnes;
    assign sec_tens = r_lapHeld ? r_lapSecTens : r_secTens;
    assign min_ones = r_lapHeld ? r_lapMinOnes : r_minOnes;
    assign min_tens = r_lapHeld ? r_lapMinTens : r_minTens;
`else
    assign sec_ones = r_secOnes;
    assign sec_tens = r_secTens;
    assign min_ones = r_minOnes;
    assign min_tens = r_minTens;
`endif

    assign running = r_running;
    assign wrap    = r_wrap;

endmodule
